// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock with a registered ripple carry,
// start/busy/done handshake. Define SERIAL_ADD_SUB_SAT_EN to saturate sum on signed overflow.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one digit added per clock, N clocks
    // DONE  | results updated this cycle; start here chains straight into RUN

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_add_sub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT:0]   dig_add;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_fin;
    logic             a_msb, b_msb, ovf_nxt;
    logic             accept, last;

    assign accept = (state != RUN) && start;
    assign last   = (state == RUN) && (cnt == CNT_LAST);

    assign dig_add = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(dig_add[DIGIT-1:0]) << (WIDTH - DIGIT));

    // On the last digit the low bits of the shifters hold the operand sign bits.
    assign a_msb   = a_sh[DIGIT-1];
    assign b_msb   = b_sh[DIGIT-1];
    assign ovf_nxt = (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);

`ifdef SERIAL_ADD_SUB_SAT_EN
    always_comb begin
        sum_fin = res_nxt;
        if (ovf_nxt) begin
            sum_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum_fin = res_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            res_sh <= '0;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            res_sh <= res_nxt;
            carry  <= dig_add[DIGIT];
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= sum_fin;
                cout <= dig_add[DIGIT];
                ovf  <= ovf_nxt;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: arithmetic reference model compared every cycle,
// directed literal cases, and 16-bit instances with DIGIT=4 and DIGIT=16.
module tb_serial_add_sub;

    localparam int N8 = 8;

    logic       clk = 1'b0;
    logic       reset, start, cin, sub;
    logic [7:0] a, b;
    logic [7:0] sum;
    logic       cout, ovf, busy, done;

    logic        s16_start, cin16, sub16;
    logic [15:0] a16, b16;
    logic [15:0] sum_d4, sum_d16;
    logic        cout_d4, ovf_d4, busy_d4, done_d4;
    logic        cout_d16, ovf_d16, busy_d16, done_d16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut_d4 (
        .clk(clk), .reset(reset), .start(s16_start), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .sum(sum_d4), .cout(cout_d4), .ovf(ovf_d4), .busy(busy_d4), .done(done_d4)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut_d16 (
        .clk(clk), .reset(reset), .start(s16_start), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .sum(sum_d16), .cout(cout_d16), .ovf(ovf_d16), .busy(busy_d16), .done(done_d16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned sum for sum/cout, integer signed sum for overflow.
    function automatic void ref_op(input logic [7:0] fa, input logic [7:0] fb,
                                   input logic fc, input logic fs,
                                   output logic [7:0] rs, output logic rc, output logic ro);
        logic [8:0] u;
        int r;
        u  = {1'b0, fa} + {1'b0, (fs ? ~fb : fb)} + {8'd0, (fs ? 1'b1 : fc)};
        r  = int'($signed(fa)) + (fs ? -int'($signed(fb)) : int'($signed(fb)) + int'(fc));
        ro = (r > 127) || (r < -128);
        rs = u[7:0];
`ifdef SERIAL_ADD_SUB_SAT_EN
        if (ro) rs = (r > 0) ? 8'h7F : 8'h80;
`endif
        rc = u[8];
    endfunction

    // Model: cycles of RUN remaining, plus the published result registers.
    int         m_left = 0;
    bit         m_done = 0;
    bit         m_valid = 0;
    logic [7:0] m_sum, p_sum;
    logic       m_cout, m_ovf, p_cout, p_ovf;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_left = 0; m_done = 0; m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1;
        end else if (m_left > 0) begin
            m_left--;
            m_done = 0;
            if (m_left == 0) begin
                m_done = 1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else begin
            m_done = 0;
            if (start) begin
                ref_op(a, b, cin, sub, p_sum, p_cout, p_ovf);
                m_left = N8;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("sum",  32'(sum),  32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf",  32'(ovf),  32'(m_ovf));
        end
    end

    // Wait (bounded) for done on the 8-bit DUT; lat = edges since edge t0.
    task automatic wait_done(input int t0, output int lat, output bit got);
        got = 0; lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin got = 1; lat = cyc - t0; end
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo, input string nm);
        int t0, lat, bcnt;
        bit got;
        @(posedge clk); #2;
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; bcnt = int'(busy);
        #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        got = 0; lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (done) begin got = 1; lat = cyc - t0; end
            else bcnt += int'(busy);
        end
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(N8));
        chk({nm, " busy_cycles"}, 32'(bcnt), 32'(N8));
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(ec));
        chk({nm, " ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic op16(input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int t0, lat4, lat16;
        @(posedge clk); #2;
        a16 = ta; b16 = tb; s16_start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; lat4 = 0; lat16 = 0;
        #1;
        s16_start = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_d4 && lat4 == 0) begin
                lat4 = cyc - t0;
                chk({nm, " d4 sum"}, 32'(sum_d4), 32'(es));
                chk({nm, " d4 cout"}, 32'(cout_d4), 32'(ec));
                chk({nm, " d4 ovf"}, 32'(ovf_d4), 32'(eo));
            end
            if (done_d16 && lat16 == 0) begin
                lat16 = cyc - t0;
                chk({nm, " d16 sum"}, 32'(sum_d16), 32'(es));
                chk({nm, " d16 cout"}, 32'(cout_d16), 32'(ec));
                chk({nm, " d16 ovf"}, 32'(ovf_d16), 32'(eo));
            end
        end
        chk({nm, " d4 latency"}, 32'(lat4), 32'd4);
        chk({nm, " d16 latency"}, 32'(lat16), 32'd1);
    endtask

    initial begin
        int t0, lat, ndone;
        bit got;
        int dt[3];
        reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        s16_start = 1'b0; a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0; sub16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        #1 reset = 1'b0;

        do_op(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, "add_3c_05");
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
`ifdef SERIAL_ADD_SUB_SAT_EN
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, "add_7f_01");
`else
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
`endif
        do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
`ifdef SERIAL_ADD_SUB_SAT_EN
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, "sub_80_01");
`else
        do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
`endif
        do_op(8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, "add_cin");

        // Reset during the 4th RUN cycle aborts with no done.
        @(posedge clk); #2;
        a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        #1 reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        do_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "after_abort");

        // Start while busy is ignored.
        @(posedge clk); #2;
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done(t0, lat, got);
        chk("busy_start done_seen", 32'(got), 32'd1);
        chk("busy_start latency", 32'(lat), 32'(N8));
        chk("busy_start sum", 32'(sum), 32'h46);

        // Start held high: back-to-back ops, done every N+1 cycles.
        @(posedge clk); #2;
        a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(cyc, lat, got);
            chk("b2b done_seen", 32'(got), 32'd1);
            dt[k] = cyc;
            chk("b2b sum", 32'(sum), 32'h03);
        end
        chk("b2b spacing1", 32'(dt[1] - dt[0]), 32'(N8 + 1));
        chk("b2b spacing2", 32'(dt[2] - dt[1]), 32'(N8 + 1));
        #1 start = 1'b0;
        repeat (12) @(posedge clk);

        // Random traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            reset = ($urandom_range(0, 599) == 0);
        end
        #1 start = 1'b0; reset = 1'b0;
        repeat (12) @(posedge clk);

        op16(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "w16_ffff_1");
`ifdef SERIAL_ADD_SUB_SAT_EN
        op16(16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "w16_7fff_1");
`else
        op16(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "w16_7fff_1");
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
